sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
- REQ-001: Parameter DATASIZE, default 8, data word width in bits.
- REQ-002: Parameter ADDRSIZE, default 4, address width; depth DEPTH = 2^ADDRSIZE words.
- REQ-003: Parameter AFULL_THRESH, default DEPTH-2, occupancy at or above which w_almost_full_o asserts.
- REQ-004: Parameter AEMPTY_THRESH, default 2, occupancy at or below which r_almost_empty_o asserts.
- REQ-005: clk_i  in  1  single clock; all logic rising-edge.
- REQ-006: rst_i  in  1  reset, synchronous, active-high.
- REQ-007: clr_i  in  1  synchronous flush; empties FIFO without touching memory contents.
- REQ-008: wdata_i  in  DATASIZE  write data.
- REQ-009: winc_i  in  1  write request.
- REQ-010: rinc_i  in  1  read request.
- REQ-011: rdata_o  out  DATASIZE  read data.
- REQ-012: wfull_o  out  1  occupancy == DEPTH.
- REQ-013: rempty_o  out  1  occupancy == 0.
- REQ-014: w_almost_full_o  out  1  occupancy >= AFULL_THRESH.
- REQ-015: r_almost_empty_o  out  1  occupancy <= AEMPTY_THRESH.
- REQ-016: count_o  out  ADDRSIZE+1  current occupancy, 0..DEPTH.
- REQ-017: overflow_o  out  1  sticky: write attempted while full.
- REQ-018: underflow_o  out  1  sticky: read attempted while empty.

Function
- REQ-019: A write SHALL be accepted when winc_i=1 and wfull_o=0; wdata_i stored at the write address, write address incremented mod DEPTH.
- REQ-020: A read SHALL be accepted when rinc_i=1 and rempty_o=0; read address incremented mod DEPTH.
- REQ-021: Rejected write (winc_i=1, wfull_o=1) SHALL leave state unchanged and set overflow_o the next cycle; rejected read likewise sets underflow_o.
- REQ-022: count_o SHALL update the cycle after acceptance: +1 write only, -1 read only, unchanged for both or neither.
- REQ-023: Simultaneous read and write at full: read accepted, write rejected, overflow_o set, count_o becomes DEPTH-1.
- REQ-024: Simultaneous read and write at empty: write accepted, read rejected, underflow_o set, count_o becomes 1.
- REQ-025: Simultaneous accepted read and write at 0 < count < DEPTH: both accepted, count unchanged.
- REQ-026: All status outputs (wfull_o, rempty_o, almost flags, count_o) SHALL be registered and mutually consistent with count_o in the same cycle.
- REQ-027: Addresses SHALL wrap from DEPTH-1 to 0 without data loss.
- REQ-028: clr_i=1 SHALL, next cycle, zero both addresses and count_o, set rempty_o=1, r_almost_empty_o=1, clear wfull_o and w_almost_full_o; overflow_o/underflow_o preserved; winc_i/rinc_i ignored that cycle.
- REQ-029: Priority SHALL be rst_i > clr_i > read/write.
- REQ-030: Legal parameters: 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH; an illegal set SHALL fail elaboration.

Reset
- REQ-031: rst_i=1 at a clock edge SHALL set: addresses 0, count_o=0, rempty_o=1, wfull_o=0, r_almost_empty_o=1, w_almost_full_o=0, overflow_o=0, underflow_o=0, rdata_o=0.
- REQ-032: Reset mid-operation SHALL discard all stored words; memory array itself need not be cleared.
- REQ-033: Sticky error flags SHALL clear only on rst_i.

Configuration
- REQ-034: Macro SYNC_FIFO_FWFT_EN selects read mode.
- REQ-035: Undefined: standard mode; rdata_o registered, updated the cycle after an accepted read, holds value otherwise.
- REQ-036: Defined: first-word fall-through; rdata_o shows the head word whenever rempty_o=0 with no request, rinc_i pops it; a write into an empty FIFO appears on rdata_o the cycle rempty_o deasserts; rdata_o=0 while empty in reset state.

Verification
- REQ-037: Reset, write 0x11,0x22,0x33, read 3 -> rdata_o 0x11,0x22,0x33 in order (standard: 1 cycle after each rinc_i); count_o 3 then 0; rempty_o=1.
- REQ-038: ADDRSIZE=4: write 16 words -> wfull_o=1, count_o=16, w_almost_full_o=1 from count 14; 17th write -> overflow_o=1, data unchanged.
- REQ-039: Read on empty after reset -> underflow_o=1, count_o=0, rdata_o unchanged; stays set until rst_i.
- REQ-040: At full, winc_i=rinc_i=1 -> count_o=15, overflow_o=1; at empty both -> count_o=1, underflow_o=1.
- REQ-041: 40 writes/reads interleaved across wrap with count 5 -> all data ordered; clr_i pulse -> count_o=0, rempty_o=1 next cycle, errors preserved.
- REQ-042: With SYNC_FIFO_FWFT_EN, write 0xA5 into empty -> next cycle rempty_o=0 and rdata_o=0xA5 without rinc_i.

Source files
------------

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered status flags, occupancy
//                count, sticky overflow/underflow flags and synchronous flush.
//                Optional feature macro: SYNC_FIFO_FWFT_EN
//                  undefined -> standard mode (rdata_o updates the cycle after
//                               an accepted read and holds otherwise)
//                  defined   -> first-word fall-through (rdata_o presents the
//                               head word whenever the FIFO is not empty)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DATASIZE      = 8,
  parameter int ADDRSIZE      = 4,
  parameter int AFULL_THRESH  = (1 << ADDRSIZE) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic                winc_i,
  input  logic                rinc_i,
  output logic [DATASIZE-1:0] rdata_o,
  output logic                wfull_o,
  output logic                rempty_o,
  output logic                w_almost_full_o,
  output logic                r_almost_empty_o,
  output logic [ADDRSIZE:0]   count_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam int DEPTH = 1 << ADDRSIZE;

  localparam logic [ADDRSIZE:0] c_depth  = DEPTH[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] c_afull  = AFULL_THRESH[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] c_aempty = AEMPTY_THRESH[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] c_one    = {{ADDRSIZE{1'b0}}, 1'b1};
  localparam logic [ADDRSIZE-1:0] c_ainc = {{(ADDRSIZE-1){1'b0}}, 1'b1};

  // Reject threshold sets that would make the almost flags meaningless.
  generate
    if ((ADDRSIZE < 1) || (AEMPTY_THRESH < 0) ||
        (AEMPTY_THRESH >= AFULL_THRESH) || (AFULL_THRESH > DEPTH)) begin : g_bad_params
      $error("sync_fifo: illegal parameters (need 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH)");
    end
  endgenerate

  // Storage and state
  logic [DATASIZE-1:0] r_mem [DEPTH];
  logic [ADDRSIZE-1:0] r_waddr;
  logic [ADDRSIZE-1:0] r_raddr;
  logic [ADDRSIZE:0]   r_count;
  logic                r_full;
  logic                r_empty;
  logic                r_afull;
  logic                r_aempty;
  logic                r_ovf;
  logic                r_unf;
  logic [DATASIZE-1:0] r_rdata;

  // Next-state helpers
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic [ADDRSIZE:0]   w_count_nxt;
  logic [ADDRSIZE-1:0] w_waddr_nxt;
  logic [ADDRSIZE-1:0] w_raddr_nxt;
  logic [DATASIZE-1:0] w_rdata_nxt;

  // Acceptance decisions use the registered flags, so full/empty corner
  // cases resolve as "read wins at full, write wins at empty".
  always_comb begin
    w_wr_ok     = winc_i & ~r_full;
    w_rd_ok     = rinc_i & ~r_empty;
    w_waddr_nxt = w_wr_ok ? (r_waddr + c_ainc) : r_waddr;
    w_raddr_nxt = w_rd_ok ? (r_raddr + c_ainc) : r_raddr;
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + c_one;
      2'b01:   w_count_nxt = r_count - c_one;
      default: w_count_nxt = r_count;
    endcase
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Next head word: zero when the FIFO drains, the incoming word when it is
  // the only entry left, otherwise the stored word at the next read address.
  always_comb begin
    w_rdata_nxt = r_mem[w_raddr_nxt];
    if (w_count_nxt == '0) begin
      w_rdata_nxt = '0;
    end else if (w_wr_ok && (w_raddr_nxt == r_waddr)) begin
      w_rdata_nxt = wdata_i;
    end
  end
`else
  // Standard mode: the addressed word is captured only on an accepted read.
  always_comb begin
    w_rdata_nxt = w_rd_ok ? r_mem[r_raddr] : r_rdata;
  end
`endif

  // Memory array is never reset; flush and reset only move the pointers.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !clr_i && w_wr_ok) begin
      r_mem[r_waddr] <= wdata_i;
    end
  end

  // Pointers, occupancy, registered status flags and read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_waddr  <= '0;
      r_raddr  <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_rdata  <= '0;
    end else if (clr_i) begin
      // Flush: requests this cycle are ignored and sticky errors survive.
      r_waddr  <= '0;
      r_raddr  <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      r_rdata  <= '0;
`endif
    end else begin
      r_waddr  <= w_waddr_nxt;
      r_raddr  <= w_raddr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == c_depth);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= c_afull);
      r_aempty <= (w_count_nxt <= c_aempty);
      r_rdata  <= w_rdata_nxt;
      if (winc_i && r_full) begin
        r_ovf <= 1'b1;
      end
      if (rinc_i && r_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    rdata_o          = r_rdata;
    wfull_o          = r_full;
    rempty_o         = r_empty;
    w_almost_full_o  = r_afull;
    r_almost_empty_o = r_aempty;
    count_o          = r_count;
    overflow_o       = r_ovf;
    underflow_o      = r_unf;
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
//  Module      : tb_sync_fifo
//  Description : Self-checking bench for sync_fifo (default parameters).
//                Queue-based reference model checked every cycle, plus
//                directed literal checks of the key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [7:0] rdata;
  logic       wfull, rempty, afull, aempty, ovf, unf;
  logic [4:0] count;

  always #5 clk = ~clk;

  sync_fifo dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .clr_i           (clr),
    .wdata_i         (wdata),
    .winc_i          (winc),
    .rinc_i          (rinc),
    .rdata_o         (rdata),
    .wfull_o         (wfull),
    .rempty_o        (rempty),
    .w_almost_full_o (afull),
    .r_almost_empty_o(aempty),
    .count_o         (count),
    .overflow_o      (ovf),
    .underflow_o     (unf)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus sticky flags.
  logic [7:0] q[$];
  bit         m_ovf = 0;
  bit         m_unf = 0;
  logic [7:0] m_rdata = 8'h00;
  bit         m_valid = 0;
  bit         m_rd, m_wr;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf   = 0;
      m_unf   = 0;
      m_rdata = 8'h00;
      m_valid = 1;
    end else if (clr) begin
      q.delete();
    end else begin
      m_rd = rinc && (q.size() > 0);
      m_wr = winc && (q.size() < DEPTH);
      if (winc && !m_wr) m_ovf = 1;
      if (rinc && !m_rd) m_unf = 1;
      if (m_rd) m_rdata = q.pop_front();
      if (m_wr) q.push_back(wdata);
    end
`ifdef SYNC_FIFO_FWFT_EN
    m_rdata = (q.size() > 0) ? q[0] : 8'h00;
`endif
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("count",  32'(count),  32'(q.size()));
      chk("wfull",  32'(wfull),  32'(q.size() == DEPTH));
      chk("rempty", 32'(rempty), 32'(q.size() == 0));
      chk("afull",  32'(afull),  32'(q.size() >= DEPTH - 2));
      chk("aempty", 32'(aempty), 32'(q.size() <= 2));
      chk("ovf",    32'(ovf),    32'(m_ovf));
      chk("unf",    32'(unf),    32'(m_unf));
      chk("rdata",  32'(rdata),  32'(m_rdata));
    end
  end

  // One clock of stimulus; returns 1 ns after the edge it was sampled on.
  task automatic step(input bit r_s, input bit c, input bit w, input bit rd, input logic [7:0] d);
    @(negedge clk);
    rst = r_s; clr = c; winc = w; rinc = rd; wdata = d;
    @(posedge clk);
    #1;
    rst = 0; clr = 0; winc = 0; rinc = 0;
  endtask

  logic [7:0] v;
  bit         save_ovf, save_unf;
  int         wp, rp;

  initial begin
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    chk("rst_count", 32'(count), 0);
    chk("rst_rempty", 32'(rempty), 1);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_aempty", 32'(aempty), 1);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_flags", {30'd0, ovf, unf}, 0);

    // Three words in, three out in order.
    step(0, 0, 1, 0, 8'h11);
    step(0, 0, 1, 0, 8'h22);
    step(0, 0, 1, 0, 8'h33);
    chk("w3_count", 32'(count), 3);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_head", 32'(rdata), 32'h11);
`endif
    step(0, 0, 0, 1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rd1", 32'(rdata), 32'h11);
`endif
    step(0, 0, 0, 1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rd2", 32'(rdata), 32'h22);
`endif
    step(0, 0, 0, 1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rd3", 32'(rdata), 32'h33);
`endif
    chk("r3_count", 32'(count), 0);
    chk("r3_rempty", 32'(rempty), 1);

    // Underflow on empty.
    step(0, 0, 0, 1, 8'h00);
    chk("unf_set", 32'(unf), 1);
    chk("unf_count", 32'(count), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("unf_rdata", 32'(rdata), 32'h33);
`endif

    // Fill to full, watching the almost-full threshold.
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 0, 8'(i * 3 + 1));
      if (i == 12) chk("afull_13", 32'(afull), 0);
      if (i == 13) chk("afull_14", 32'(afull), 1);
    end
    chk("full_wfull", 32'(wfull), 1);
    chk("full_count", 32'(count), 16);
    step(0, 0, 1, 0, 8'hEE);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_count", 32'(count), 16);
    step(0, 0, 0, 1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
    chk("ovf_data", 32'(rdata), 32'h01);
`endif
    step(0, 0, 1, 0, 8'h77);
    step(0, 0, 1, 1, 8'h88);
    chk("both_full_count", 32'(count), 15);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 8'h00);
    chk("drained", 32'(rempty), 1);
    step(0, 0, 1, 1, 8'h99);
    chk("both_empty_count", 32'(count), 1);
    chk("both_empty_unf", 32'(unf), 1);
    step(0, 0, 0, 1, 8'h00);
    chk("both_empty_data", 32'(rdata), 32'h99 * 32'(!`ifdef SYNC_FIFO_FWFT_EN 1 `else 0 `endif));

    // Reset clears sticky flags; interleave across the wrap at count 5.
    step(1, 0, 0, 0, 8'h00);
    chk("rst2_flags", {30'd0, ovf, unf}, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) step(0, 0, 1, 1, 8'($urandom));
    chk("il_count", 32'(count), 5);
    step(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    save_ovf = ovf;
    save_unf = unf;
    chk("pre_clr_ovf", 32'(save_ovf), 1);
    step(0, 1, 1, 1, 8'h5A);
    chk("clr_count", 32'(count), 0);
    chk("clr_rempty", 32'(rempty), 1);
    chk("clr_ovf_kept", 32'(ovf), 32'(save_ovf));
    chk("clr_unf_kept", 32'(unf), 32'(save_unf));
    step(0, 0, 0, 1, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    chk("clr_unf_sticky", 32'(unf), 1);

    // Randomized traffic with varying fill pressure, flushes and resets.
    for (int ph = 0; ph < 12; ph++) begin
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 200; i++) begin
        v = 8'($urandom);
        step($urandom_range(0, 699) == 0, $urandom_range(0, 63) == 0,
             $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, v);
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
